// File: rtl/seq_div_pkg.sv
// Shared types for the sequential divider: ALU opcodes and FSM states.
package seq_div_pkg;

    typedef enum logic [2:0] {
        ALU_DIV  = 3'd0,
        ALU_DIVU = 3'd1,
        ALU_REM  = 3'd2,
        ALU_REMU = 3'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        FIX     = 3'd2,
        SPECIAL = 3'd3,
        DONE    = 3'd4
    } div_state_t;

    function automatic logic is_div_op(alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(alu_op_t op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational radix-2 restoring step: shift {acc,quo} left, subtract divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    assign shifted  = {acc[WIDTH-1:0], quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    // A set top bit would be shifted out, so the shifted value certainly exceeds the divisor.
    assign fits     = acc[WIDTH] || (shifted >= {1'b0, divisor});
    assign acc_next = fits ? diff : shifted;
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider with RISC-V M semantics and valid/ready handshakes.
// Optional build macro SEQ_DIV_EARLY_OUT_EN: |dividend| < |divisor| short-cuts to a 2-cycle result.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    STEP    = CW'(STEPS_PER_CYCLE);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - STEPS_PER_CYCLE);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_quo;
    logic             neg_rem;
    logic             rem_sel;

    logic             accept;
    logic             op_signed;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             overflow;
    logic             early;
    logic             special;
    logic [WIDTH-1:0] special_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign accept    = in_valid && in_ready && is_div_op(op);
    assign op_signed = is_signed_op(op);
    assign neg_a     = op_signed && dividend[WIDTH-1];
    assign neg_b     = op_signed && divisor[WIDTH-1];
    assign mag_a     = neg_a ? -dividend : dividend;
    assign mag_b     = neg_b ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = op_signed && (dividend == MOST_NEG) && (divisor == '1);

`ifdef SEQ_DIV_EARLY_OUT_EN
    assign early = !div_zero && (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    assign special = div_zero || overflow || early;

    // Divide-by-zero and early-out both return the raw dividend as remainder.
    always_comb begin
        special_res = '0;
        if (is_rem_op(op))
            special_res = overflow ? '0 : dividend;
        else if (div_zero)
            special_res = '1;
        else if (overflow)
            special_res = MOST_NEG;
    end

    logic [STEPS_PER_CYCLE:0][WIDTH:0]   acc_chain;
    logic [STEPS_PER_CYCLE:0][WIDTH-1:0] quo_chain;

    assign acc_chain[0] = acc;
    assign quo_chain[0] = quo;

    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .acc      (acc_chain[k]),
            .quo      (quo_chain[k]),
            .divisor  (dvs),
            .acc_next (acc_chain[k+1]),
            .quo_next (quo_chain[k+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            rem_sel <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_sel <= is_rem_op(op);
                        neg_quo <= neg_a ^ neg_b;
                        neg_rem <= neg_a;
                        dvs     <= mag_b;
                        acc     <= '0;
                        cnt     <= '0;
                        if (special) begin
                            quo   <= special_res;
                            state <= SPECIAL;
                        end else begin
                            quo   <= mag_a;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_chain[STEPS_PER_CYCLE];
                    quo <= quo_chain[STEPS_PER_CYCLE];
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                FIX: begin
                    if (rem_sel)
                        result <= neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    else
                        result <= neg_quo ? -quo : quo;
                    state <= DONE;
                end
                SPECIAL: begin
                    result <= quo;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div; latency counts clock edges from the accepting edge inclusive.
module tb_seq_div;
    import seq_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid4, out_ready;
    alu_op_t     op;
    logic [31:0] dividend, divisor;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    seq_div #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4), .busy(busy4)
    );

`ifdef SEQ_DIV_EARLY_OUT_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 34;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input bit s, input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; dividend = a; divisor = b;
        if (s) in_valid4 = 1'b1;
        else   in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
    endtask

    task automatic wait_out(input bit s, input logic [31:0] exp, input int exp_lat, input string tag);
        int lat = 1;
        bit rdy_seen = 1'b0;
        while (!(s ? out_valid4 : out_valid) && lat < 200) begin
            if (s ? in_ready4 : in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " out_valid"}, 32'(s ? out_valid4 : out_valid), 32'd1);
        chk({tag, " result"}, s ? result4 : result, exp);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " in_ready low"}, 32'(rdy_seen | (s ? in_ready4 : in_ready)), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " in_ready after"}, 32'(in_ready & in_ready4), 32'd1);
    endtask

    task automatic run(input bit s, input alu_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
        issue(s, o, a, b);
        wait_out(s, exp, lat, tag);
        release_out(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
        op = ALU_DIV; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result",    result,         32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        @(negedge clk) rst = 1'b0;

        // Signed
        run(0, ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "DIV -7/2");
        run(0, ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "REM -7/2");
        run(0, ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 34, "REM 7/-2");
        run(0, ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "DIV 7/-2");

        // Unsigned
        run(0, ALU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34, "DIVU ffffffff/16");
        run(0, ALU_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34, "REMU ffffffff/16");

        // Special cases
        run(0, ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "DIVU 5/0");
        run(0, ALU_REM,  32'd5, 32'd0, 32'd5, 2, "REM 5/0");
        run(0, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "DIV ovf");
        run(0, ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, "REM ovf");

        // Dividend smaller than divisor: early-out candidate
        run(0, ALU_DIVU, 32'd3, 32'd10, 32'd0, SMALL_LAT, "DIVU 3/10");
        run(0, ALU_REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, SMALL_LAT, "REM -3/10");

        // Illegal op is ignored
        @(negedge clk);
        op = alu_op_t'(3'd6); dividend = 32'd9; divisor = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bad op busy",     32'(busy),     32'd0);
        chk("bad op in_ready", 32'(in_ready), 32'd1);

        // Backpressure in DONE
        issue(0, ALU_DIV, 32'd100, 32'd7);
        wait_out(0, 32'd14, 34, "bp DIV 100/7");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = ALU_DIVU; dividend = 32'd1; divisor = 32'd1;
            @(posedge clk); #1;
            chk("bp result held", result, 32'd14);
            chk("bp out_valid held", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_out("bp");
        chk("bp ignored request", 32'(busy), 32'd0);

        // Four steps per cycle
        run(1, ALU_DIVU, 32'd100, 32'd7, 32'd14, 10, "x4 DIVU 100/7");
        run(1, ALU_REMU, 32'd100, 32'd7, 32'd2, 10, "x4 REMU 100/7");

        // Reset in the middle of CALC
        issue(0, ALU_DIVU, 32'd1000, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst in_ready",  32'(in_ready),  32'd1);
        chk("mid rst busy",      32'(busy),      32'd0);
        @(negedge clk) rst = 1'b0;
        run(0, ALU_DIVU, 32'd9, 32'd3, 32'd3, 34, "DIVU 9/3 after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
